// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the parking gate arbiter and password datapath.
package parking_pkg;

  typedef enum logic [1:0] {StIdle, StAuth, StOpen, StHoldoff} state_e;
  typedef enum logic {DirEntry, DirExit} dir_e;

  localparam int unsigned DefCapacity      = 4;
  localparam int unsigned DefOpenCycles    = 126829120;
  localparam int unsigned DefTimeoutCycles = 1000000000;

endpackage

// File: rtl/parking_timer.sv
// Loadable down-counter; expire_o is high while the count sits at zero.
module parking_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter sharing one barrier gate and password checker between entrance and exit.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY       = DefCapacity,
  parameter int unsigned OPEN_CYCLES    = DefOpenCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned CNT_W          = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sensor_entrance,
  input  logic             sensor_exit,
  input  logic             auth_done,
  input  logic             auth_ok,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             gate_open,
  output logic             busy,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] num_cars
);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  dir_e             last_q, last_d;
  logic [CNT_W-1:0] cars_q, cars_d;
  logic             elig_ent, elig_ext, served_sensor;
  logic             tmr_load, tmr_expire;
  logic [31:0]      tmr_val;

  assign elig_ent      = sensor_entrance && (cars_q < CNT_W'(CAPACITY));
  assign elig_ext      = sensor_exit && (cars_q != '0);
  assign served_sensor = (dir_q == DirEntry) ? sensor_entrance : sensor_exit;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    last_d  = last_q;
    cars_d  = cars_q;
    unique case (state_q)
      StIdle: begin
        // On a tie the lane that lost last time wins.
        if (elig_ent && (!elig_ext || last_q == DirExit)) begin
          state_d = StAuth;
          dir_d   = DirEntry;
          last_d  = DirEntry;
        end else if (elig_ext) begin
          state_d = StAuth;
          dir_d   = DirExit;
          last_d  = DirExit;
        end
      end
      StAuth: begin
        // auth_done beats a timeout landing on the same cycle.
        if (auth_done) begin
          if (auth_ok) begin
            state_d = StOpen;
            cars_d  = (dir_q == DirEntry) ? cars_q + 1'b1 : cars_q - 1'b1;
          end else begin
            state_d = StHoldoff;
          end
        end else if (tmr_expire) begin
          state_d = StHoldoff;
        end
      end
      StOpen: begin
        if (tmr_expire) state_d = StHoldoff;
      end
      StHoldoff: begin
        if (!served_sensor) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Timer reloads on every state change so one counter covers both AUTH and OPEN.
  assign tmr_load = (state_d != state_q);
  assign tmr_val  = (state_d == StOpen) ? OPEN_CYCLES - 1 : TIMEOUT_CYCLES - 1;

  parking_timer #(
    .Width (32)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= StIdle;
      dir_q       <= DirEntry;
      last_q      <= DirExit;
      cars_q      <= '0;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      gate_open   <= 1'b0;
      busy        <= 1'b0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      last_q      <= last_d;
      cars_q      <= cars_d;
      grant_entry <= (state_d == StAuth) && (dir_d == DirEntry);
      grant_exit  <= (state_d == StAuth) && (dir_d == DirExit);
      gate_open   <= (state_d == StOpen);
      busy        <= (state_d != StIdle);
      full        <= (cars_d == CNT_W'(CAPACITY));
      empty       <= (cars_d == '0);
    end
  end

  assign num_cars = cars_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboard bench: a lane/occupancy model queues the expected grant and count per transaction.
module tb_parking_gate_arbiter;

  localparam int unsigned Cap     = 4;
  localparam int unsigned OpenCyc = 10;
  localparam int unsigned ToCyc   = 50;

  typedef struct packed {
    logic [1:0] dir;   // {grant_entry, grant_exit}
    logic [2:0] cars;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sens_ent = 1'b0;
  logic       sens_ext = 1'b0;
  logic       auth_done = 1'b0;
  logic       auth_ok = 1'b0;
  logic       grant_entry, grant_exit, gate_open, busy, full, empty;
  logic [2:0] num_cars;

  exp_t        exp_q[$];
  int unsigned m_cars = 0;
  bit          m_last_exit = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;

  parking_gate_arbiter #(
    .CAPACITY       (Cap),
    .OPEN_CYCLES    (OpenCyc),
    .TIMEOUT_CYCLES (ToCyc)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sens_ent),
    .sensor_exit     (sens_ext),
    .auth_done       (auth_done),
    .auth_ok         (auth_ok),
    .grant_entry     (grant_entry),
    .grant_exit      (grant_exit),
    .gate_open       (gate_open),
    .busy            (busy),
    .full            (full),
    .empty           (empty),
    .num_cars        (num_cars)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_count(input string tag, input int unsigned cars);
    check_val({tag, "_cars"}, 32'(num_cars), cars);
    check_val({tag, "_full"}, 32'(full), 32'(cars == Cap));
    check_val({tag, "_empty"}, 32'(empty), 32'(cars == 0));
  endtask

  // dly: AUTH cycle on which auth_done pulses (0 = never, let it time out).
  task automatic txn(input bit ok, input int unsigned dly, input bit rst_mid);
    exp_t        e, got;
    bit          ge, gx;
    int unsigned n;
    ge = sens_ent && (m_cars < Cap);
    gx = sens_ext && (m_cars > 0);
    if (ge && gx) e.dir = m_last_exit ? 2'b10 : 2'b01;
    else          e.dir = {ge, gx};
    if (e.dir != 2'b00) m_last_exit = e.dir[0];
    e.cars = 3'(m_cars);
    if (e.dir != 2'b00 && ok && dly != 0) e.cars = e.dir[1] ? 3'(m_cars + 1) : 3'(m_cars - 1);
    exp_q.push_back(e);

    @(negedge clk);
    got = exp_q.pop_front();
    check_val("grant", 32'({grant_entry, grant_exit}), 32'(got.dir));
    if (got.dir == 2'b00) begin
      check_val("no_grant_busy", 32'(busy), 0);
      return;
    end
    check_val("auth_busy", 32'(busy), 1);

    if (dly == 0) begin
      repeat (ToCyc - 1) @(negedge clk);
      check_val("grant_hold", 32'({grant_entry, grant_exit}), 32'(got.dir));
      @(negedge clk);
      check_val("timeout_grant", 32'({grant_entry, grant_exit}), 0);
      check_val("timeout_gate", 32'(gate_open), 0);
      check_count("timeout", got.cars);
    end else begin
      repeat (dly - 1) @(negedge clk);
      auth_done = 1'b1;
      auth_ok   = ok;
      @(negedge clk);
      auth_done = 1'b0;
      auth_ok   = 1'b0;
      check_val("done_grant", 32'({grant_entry, grant_exit}), 0);
      check_count("done", got.cars);
      if (ok) begin
        check_val("gate_rise", 32'(gate_open), 1);
        if (rst_mid) begin
          reset_n  = 1'b0 ^ 1'b1;
          sens_ent = 1'b0;
          sens_ext = 1'b0;
          @(negedge clk);
          reset_n = 1'b0;
          check_val("rst_gate", 32'(gate_open), 0);
          check_val("rst_busy", 32'(busy), 0);
          check_count("rst", 0);
          m_cars      = 0;
          m_last_exit = 1'b1;
          return;
        end
        n = 0;
        while (gate_open && n < 40) begin
          n++;
          @(negedge clk);
        end
        check_val("open_len", n, OpenCyc);
      end else begin
        check_val("fail_gate", 32'(gate_open), 0);
      end
    end
    m_cars = got.cars;

    // Served car still waiting: no re-grant.
    repeat (3) @(negedge clk);
    check_val("holdoff_busy", 32'(busy), 1);
    check_val("holdoff_grant", 32'({grant_entry, grant_exit}), 0);
    check_val("holdoff_gate", 32'(gate_open), 0);
    if (got.dir[1]) sens_ent = 1'b0;
    else            sens_ext = 1'b0;
    @(negedge clk);
    check_val("back_idle", 32'(busy), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_gate", 32'(gate_open), 0);
    check_val("rst_grant", 32'({grant_entry, grant_exit}), 0);
    check_count("rst", 0);

    // Entry success, then build up to 2 cars with last grant on exit.
    sens_ent = 1'b1; txn(1'b1, 3, 1'b0);
    sens_ent = 1'b1; txn(1'b1, 2, 1'b0);
    sens_ent = 1'b1; txn(1'b1, 1, 1'b0);
    sens_ext = 1'b1; txn(1'b1, 4, 1'b0);

    // Both lanes requesting with 2 cars: entrance then exit.
    sens_ent = 1'b1; sens_ext = 1'b1;
    txn(1'b1, 3, 1'b0);
    txn(1'b1, 3, 1'b0);
    check_count("rr_final", 2);

    // Fill the lot, then a full entrance is ignored while the exit is served.
    sens_ent = 1'b1; txn(1'b1, 2, 1'b0);
    sens_ent = 1'b1; txn(1'b1, 2, 1'b0);
    sens_ent = 1'b1; txn(1'b1, 2, 1'b0);
    repeat (4) @(negedge clk);
    check_val("full_busy", 32'(busy), 0);
    check_val("full_grant", 32'({grant_entry, grant_exit}), 0);
    sens_ext = 1'b1; txn(1'b1, 2, 1'b0);

    // Wrong password on the still-waiting entrance car.
    txn(1'b0, 2, 1'b0);

    // Timeout, then auth_done landing on the final AUTH cycle.
    sens_ent = 1'b1; txn(1'b1, 0, 1'b0);
    sens_ent = 1'b1; txn(1'b1, ToCyc, 1'b0);

    // Reset mid-OPEN, then the entrance wins the first contest.
    sens_ext = 1'b1; txn(1'b1, 2, 1'b1);
    sens_ent = 1'b1; sens_ext = 1'b1;
    txn(1'b1, 2, 1'b0);
    txn(1'b1, 2, 1'b0);
    check_count("final", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares the single barrier gate and password checker between the entrance and exit lanes. It picks one lane at a time, hands that lane to the password checker, and holds the gate open after a successful authentication. It also keeps the authoritative occupancy count. It sits between the lane sensors and the password/LED datapath, which now only reports pass or fail.

## Interface
- CAPACITY, 4: maximum cars parked.
- OPEN_CYCLES, 126829120: cycles the gate stays open after a successful authentication.
- TIMEOUT_CYCLES, 1000000000: cycles allowed for a password entry before the grant is abandoned.
- CNT_W, $clog2(CAPACITY+1): width of the occupancy count.
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock.
  - reset_n  in  1  synchronous, active-high reset. The name is kept for codebase consistency.
- sensor_entrance  in  1  a car is present at the entrance; level signal.
- sensor_exit  in  1  a car is present at the exit; level signal.
- auth_done  in  1  one-cycle pulse from the password checker; four digits have been entered.
- auth_ok  in  1  valid only with auth_done; 1 means the password matched.
- grant_entry  out  1  the password checker serves the entrance lane.
- grant_exit  out  1  the password checker serves the exit lane.
- gate_open  out  1  barrier drive.
- busy  out  1  the arbiter is not in IDLE.
- full  out  1  num_cars == CAPACITY.
- empty  out  1  num_cars == 0.
- num_cars  out  CNT_W  current occupancy.

## Operation
- States:
  - IDLE: no lane is served.
  - AUTH: one lane is granted and a password entry is in progress.
  - OPEN: the gate is open.
  - HOLDOFF: wait for the served sensor to drop before serving again.
- Eligibility:
  - The entrance is eligible when sensor_entrance=1 and num_cars<CAPACITY.
  - The exit is eligible when sensor_exit=1 and num_cars>0.
- Transitions out of IDLE:
  - If exactly one lane is eligible, go to AUTH with that lane granted.
  - If both are eligible, grant the lane that did not receive the previous grant (round-robin). Update last_dir on every grant.
  - If no lane is eligible, stay in IDLE. A full entrance or empty exit is ignored and produces no grant.
- Transitions out of AUTH:
  - auth_done=1 and auth_ok=1: go to OPEN. Increment num_cars for an entrance grant; decrement it for an exit grant.
  - auth_done=1 and auth_ok=0: go to HOLDOFF; count unchanged.
  - No auth_done within TIMEOUT_CYCLES: go to HOLDOFF; count unchanged.
  - A sensor that drops during AUTH does not abort the grant.
- Transitions out of OPEN: after OPEN_CYCLES, go to HOLDOFF.
- Transitions out of HOLDOFF: when the served lane's sensor reads 0, go to IDLE. This prevents a waiting car from retriggering a grant.
- Outputs:
  - grant_entry and grant_exit are one-hot or both 0; asserted only in AUTH.
  - gate_open=1 only in OPEN.
  - busy=1 in all states except IDLE.
- Arithmetic: num_cars never wraps, because eligibility blocks increment at CAPACITY and decrement at 0.
- auth_done outside AUTH is ignored.
- Reset:
  - Forces IDLE. Clears all outputs and num_cars to 0, so empty=1.
  - Sets last_dir=exit, so the entrance wins the first tie.
  - Reset mid-operation abandons any grant and closes the gate on the next cycle.

## Timing
- All outputs are registered.
- A request sampled in IDLE on edge N gives grant_* = 1 after edge N, i.e. one cycle of latency.
- auth_done sampled on edge N gives gate_open=1 and the updated num_cars/full/empty after edge N.
- gate_open stays high for exactly OPEN_CYCLES clock cycles.
- The AUTH timeout fires on the TIMEOUT_CYCLES-th cycle spent in AUTH with no auth_done. If auth_done arrives in that same cycle, auth_done wins.
- The shortest HOLDOFF is 1 cycle, reached when the sensor is already low.

## Structure
- Package parking_pkg holds:
  - the state enum {IDLE, AUTH, OPEN, HOLDOFF};
  - the direction enum {DIR_ENTRY, DIR_EXIT};
  - the default CAPACITY, OPEN_CYCLES and TIMEOUT_CYCLES constants, shared with the password datapath.
- Sub-module parking_timer: a loadable down-counter with an expire pulse. One instance serves both the AUTH timeout and the OPEN hold; it is reloaded on every state entry.
- Expected size: about 200 lines of RTL.

## Test plan
- All sims use OPEN_CYCLES=10 and TIMEOUT_CYCLES=50.
- Test 1, entry success: raise sensor_entrance, then pulse auth_done with auth_ok=1 three cycles after the grant.
  - grant_entry rises 1 cycle after the request.
  - num_cars 0→1 and gate_open high for exactly 10 cycles.
  - HOLDOFF then holds until the sensor drops.
- Test 2, simultaneous requests with num_cars=2: raise both sensors and run two full successful cycles.
  - The first grant goes to the entrance, the second to the exit.
  - Final num_cars=2.
- Test 3, full lot with num_cars=4: raise sensor_entrance.
  - No grant and busy stays 0.
  - A concurrent sensor_exit is granted.
- Test 4, wrong password: pulse auth_done with auth_ok=0.
  - No gate_open and num_cars unchanged.
  - grant_entry stays 0 and no new grant is issued while the sensor stays high.
- Test 5, timeout: leave the grant idle for 50 cycles.
  - Enter HOLDOFF with num_cars unchanged.
  - auth_done arriving on cycle 50 is honoured.
- Test 6, reset mid-OPEN: assert reset_n for 1 cycle.
  - gate_open=0, num_cars=0 and empty=1 on the next cycle.
  - After reset the entrance wins the first tie.
